spart_fifo_bridge: RTL and testbench

//  Parametrised memory-mapped SPART for the cache I/O port: 8N1 UART with TX/RX FIFOs,

---
 rtl/spart_fifo_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_spart_fifo_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spart_fifo_bridge.sv
// Memory-mapped 8N1 SPART for the cache I/O window: TX/RX byte FIFOs, runtime baud
// divisor, sticky RX error flags and a 16x oversampled receiver.

module spart_fifo_bridge_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module spart_fifo_bridge #(
  parameter logic [27:0] BASE_ADDR   = 28'h800_0000,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd53
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_valid_data,
  input  logic        io_rw_data,
  input  logic [27:0] mem_addr,
  input  logic [31:0] io_wr_data,
  output logic        io_ready_data,
  output logic [31:0] io_rd_data,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);
  localparam int unsigned TXCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RXCW = $clog2(RX_DEPTH) + 1;
  localparam logic [TXCW-1:0] TX_FULL = TXCW'(TX_DEPTH);
  localparam logic [RXCW-1:0] RX_FULL = RXCW'(RX_DEPTH);

  typedef enum logic [1:0] {B_IDLE, B_STALL, B_HOLD} bus_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  bus_state_t bus_state, bus_next;
  tx_state_t  tx_state, tx_state_n;
  rx_state_t  rx_state, rx_state_n;

  logic [15:0] div_reg, baud_cnt;
  logic        tick;
  logic [7:0]  hold_byte;
  logic        complete, tx_push, rx_pop, stat_clr, div_we;
  logic [31:0] rd_val, stat_word;
  logic        sel_data, sel_stat, sel_div;

  logic [7:0]      tx_din, tx_dout, rx_dout;
  logic [TXCW-1:0] tx_count;
  logic [RXCW-1:0] rx_count;
  logic            tx_pop, rx_push, tx_empty, tx_full, rx_empty, rx_full, tx_busy;

  logic [3:0] tx_tcnt, tx_tcnt_n, rx_tcnt, rx_tcnt_n;
  logic [2:0] tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [7:0] tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic       txd_n, rx_s1, rx_s;
  logic       rx_overrun, frame_err, overrun_set, frame_set;

  spart_fifo_bridge_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(tx_din),
    .pop(tx_pop), .dout(tx_dout), .count(tx_count)
  );

  spart_fifo_bridge_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_shift),
    .pop(rx_pop), .dout(rx_dout), .count(rx_count)
  );

  assign tx_empty  = (tx_count == '0);
  assign tx_full   = (tx_count == TX_FULL);
  assign rx_empty  = (rx_count == '0);
  assign rx_full   = (rx_count == RX_FULL);
  assign tx_busy   = (tx_state != TX_IDLE);
  assign sel_data  = (mem_addr == BASE_ADDR);
  assign sel_stat  = (mem_addr == BASE_ADDR + 28'd1);
  assign sel_div   = (mem_addr == BASE_ADDR + 28'd2);
  assign stat_word = {8'h00, 8'(tx_count), 8'(rx_count), 3'b000,
                      tx_busy, frame_err, rx_overrun, ~tx_full, ~rx_empty};
  assign tx_din    = (bus_state == B_STALL) ? hold_byte : io_wr_data[7:0];
  assign tick      = (baud_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_cnt <= DEFAULT_DIV;
    else if (tick) baud_cnt <= div_reg;
    else baud_cnt <= baud_cnt - 1'b1;
  end

  // Bus side effects fire only on the completing cycle; B_HOLD blocks re-issue until valid drops.
  always_comb begin
    bus_next = bus_state;
    complete = 1'b0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    stat_clr = 1'b0;
    div_we   = 1'b0;
    rd_val   = '0;
    case (bus_state)
      B_IDLE: if (io_valid_data) begin
        if (io_rw_data && sel_data && tx_full) begin
          bus_next = B_STALL;
        end else begin
          complete = 1'b1;
          bus_next = B_HOLD;
          if (io_rw_data) begin
            tx_push = sel_data;
            div_we  = sel_div;
          end else if (sel_data) begin
            rx_pop = ~rx_empty;
            rd_val = rx_empty ? '0 : {23'd0, 1'b1, rx_dout};
          end else if (sel_stat) begin
            stat_clr = 1'b1;
            rd_val   = stat_word;
          end else if (sel_div) begin
            rd_val = {16'd0, div_reg};
          end
        end
      end
      B_STALL: if (!tx_full) begin
        complete = 1'b1;
        tx_push  = 1'b1;
        bus_next = B_HOLD;
      end
      B_HOLD:  if (!io_valid_data) bus_next = B_IDLE;
      default: bus_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state     <= B_IDLE;
      io_ready_data <= 1'b0;
      io_rd_data    <= '0;
      hold_byte     <= '0;
      div_reg       <= DEFAULT_DIV;
      rx_overrun    <= 1'b0;
      frame_err     <= 1'b0;
      irq           <= 1'b0;
    end else begin
      bus_state     <= bus_next;
      io_ready_data <= complete;
      io_rd_data    <= complete ? rd_val : '0;
      if (bus_state == B_IDLE && io_valid_data) hold_byte <= io_wr_data[7:0];
      if (div_we) div_reg <= io_wr_data[15:0];
      if (overrun_set) rx_overrun <= 1'b1;
      else if (stat_clr) rx_overrun <= 1'b0;
      if (frame_set) frame_err <= 1'b1;
      else if (stat_clr) frame_err <= 1'b0;
      irq <= ~rx_empty | rx_overrun | frame_err;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    if (tick) begin
      case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_dout;
          tx_tcnt_n  = '0;
          tx_state_n = TX_START;
        end
        TX_START: begin
          tx_tcnt_n = tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) begin
            tx_bit_n   = '0;
            tx_state_n = TX_DATA;
          end
        end
        TX_DATA: begin
          tx_tcnt_n = tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) begin
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_bit_n   = tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          end
        end
        TX_STOP: begin
          tx_tcnt_n = tx_tcnt + 1'b1;
          if (tx_tcnt == 4'd15) begin
            if (!tx_empty) begin
              tx_pop     = 1'b1;
              tx_shift_n = tx_dout;
              tx_state_n = TX_START;
            end else begin
              tx_state_n = TX_IDLE;
            end
          end
        end
        default: tx_state_n = TX_IDLE;
      endcase
    end
    case (tx_state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = tx_shift_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_tcnt_n   = rx_tcnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_push     = 1'b0;
    overrun_set = 1'b0;
    frame_set   = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_s) begin
        rx_tcnt_n  = '0;
        rx_state_n = RX_START;
      end
      RX_START: if (tick) begin
        rx_tcnt_n = rx_tcnt + 1'b1;
        if (rx_tcnt == 4'd7) begin
          rx_tcnt_n  = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (tick) begin
        rx_tcnt_n = rx_tcnt + 1'b1;
        if (rx_tcnt == 4'd15) begin
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: if (tick) begin
        rx_tcnt_n = rx_tcnt + 1'b1;
        if (rx_tcnt == 4'd15) begin
          if (rx_s) begin
            overrun_set = rx_full;
            rx_push     = ~rx_full;
            rx_state_n  = RX_IDLE;
          end else begin
            frame_set  = 1'b1;
            rx_state_n = RX_WAIT;
          end
        end
      end
      RX_WAIT: if (rx_s) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rxd;
      rx_s     <= rx_s1;
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end
endmodule

// File: tb/tb_spart_fifo_bridge.sv
// Directed bench for spart_fifo_bridge: register table, TX waveform, TX stall,
// async reset, RX frames, overrun, framing error and glitch rejection.

module tb_spart_fifo_bridge;
  localparam logic [27:0] BASE = 28'h800_0000;
  localparam logic [27:0] A_DATA = BASE;
  localparam logic [27:0] A_STAT = BASE + 28'd1;
  localparam logic [27:0] A_DIV  = BASE + 28'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_valid_data = 1'b0;
  logic        io_rw_data = 1'b0;
  logic [27:0] mem_addr = '0;
  logic [31:0] io_wr_data = '0;
  logic        io_ready_data;
  logic [31:0] io_rd_data;
  logic        rxd = 1'b1;
  logic        txd;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rw;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  spart_fifo_bridge #(
    .BASE_ADDR(BASE), .TX_DEPTH(16), .RX_DEPTH(16), .DEFAULT_DIV(16'd53)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_valid_data(io_valid_data), .io_rw_data(io_rw_data),
    .mem_addr(mem_addr), .io_wr_data(io_wr_data), .io_ready_data(io_ready_data),
    .io_rd_data(io_rd_data), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge with the bridge re-armed.
  task automatic bus(input logic rw, input logic [27:0] addr, input logic [31:0] wdata,
                     input int max_wait, output logic [31:0] rdata, output int lat);
    io_valid_data = 1'b1;
    io_rw_data    = rw;
    mem_addr      = addr;
    io_wr_data    = wdata;
    lat   = -1;
    rdata = '0;
    for (int i = 1; i <= max_wait; i++) begin
      @(negedge clk);
      if (io_ready_data) begin
        lat   = i;
        rdata = io_rd_data;
        break;
      end
    end
    io_valid_data = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input string name, input logic [27:0] addr, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    bus(1'b1, addr, d, 4, r, lat);
    check({name, "_lat"}, lat, 1);
  endtask

  task automatic rd(input string name, input logic [27:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    bus(1'b0, addr, '0, 4, r, lat);
    check(name, r, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (16) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [9:0]  tx_exp;
    int lat, f, rr;

    vecs[0]  = '{1'b0, A_STAT, 32'h0, 32'h0000_0002};
    vecs[1]  = '{1'b0, A_DIV, 32'h0, 32'h0000_0035};
    vecs[2]  = '{1'b0, A_DATA, 32'h0, 32'h0000_0000};
    vecs[3]  = '{1'b1, A_DIV, 32'hABCD_0007, 32'h0};
    vecs[4]  = '{1'b0, A_DIV, 32'h0, 32'h0000_0007};
    vecs[5]  = '{1'b1, A_STAT, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b0, A_STAT, 32'h0, 32'h0000_0002};
    vecs[7]  = '{1'b0, BASE + 28'd3, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, BASE + 28'd3, 32'h0000_0055, 32'h0};
    vecs[9]  = '{1'b0, BASE - 28'd1, 32'h0, 32'h0};
    vecs[10] = '{1'b1, A_DIV, 32'h0000_03E8, 32'h0};
    vecs[11] = '{1'b0, A_DIV, 32'h0, 32'h0000_03E8};

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_ready", io_ready_data, 0);
    check("rst_rd_data", io_rd_data, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      bus(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 4, r, lat);
      check($sformatf("vec%0d_data", i), r, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), lat, 1);
    end

    // DIV=1000 is latched by the first reload; the TX FIFO can then fill before the next tick.
    repeat (80) @(negedge clk);
    for (int i = 0; i < 16; i++) wr($sformatf("fill%0d", i), A_DATA, 32'h20 + i);
    rd("stat_tx_full", A_STAT, 32'h0010_0000);
    io_valid_data = 1'b1;
    io_rw_data    = 1'b1;
    mem_addr      = A_DATA;
    io_wr_data    = 32'h11;
    f  = -1;
    rr = -1;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (f < 0 && txd == 1'b0) f = i;
      if (io_ready_data) begin
        rr = i;
        break;
      end
    end
    io_valid_data = 1'b0;
    @(negedge clk);
    check("stall_ready_after_pop", rr - f, 1);
    check("stall_waited", rr > 100, 1);

    repeat (3) @(negedge clk);
    check("txd_low_before_reset", txd, 0);
    #2 rst_n = 1'b0;
    #1 check("txd_async_reset", txd, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("stat_after_reset", A_STAT, 32'h0000_0002);
    rd("div_after_reset", A_DIV, 32'h0000_0035);

    wr("div0", A_DIV, 32'h0);
    repeat (80) @(negedge clk);
    bus(1'b1, A_DATA, 32'h41, 4, r, lat);
    check("tx41_lat", lat, 1);
    for (int i = 0; i < 40; i++) begin
      if (txd == 1'b0) break;
      @(negedge clk);
    end
    check("tx41_start_seen", txd, 0);
    tx_exp = {1'b1, 8'h41, 1'b0};
    repeat (8) @(negedge clk);
    check("tx41_start_mid", txd, 0);
    repeat (7) @(negedge clk);
    check("tx41_start_last", txd, 0);
    @(negedge clk);
    check("tx41_bit0_first", txd, 1);
    repeat (8) @(negedge clk);
    check("tx41_bit0_mid", txd, tx_exp[1]);
    for (int b = 2; b < 10; b++) begin
      repeat (16) @(negedge clk);
      check($sformatf("tx41_bit%0d", b - 1), txd, tx_exp[b]);
    end
    repeat (24) @(negedge clk);
    rd("stat_tx_done", A_STAT, 32'h0000_0002);

    send_rx(8'h5A, 1'b1);
    send_rx(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    check("rx_irq", irq, 1);
    rd("rx_5a", A_DATA, 32'h0000_015A);
    rd("rx_c3", A_DATA, 32'h0000_01C3);
    rd("rx_empty", A_DATA, 32'h0000_0000);
    check("rx_irq_clear", irq, 0);

    send_rx(8'hA5, 1'b0);
    repeat (8) @(negedge clk);
    check("ferr_irq", irq, 1);
    rd("ferr_stat", A_STAT, 32'h0000_000A);
    rd("ferr_stat_clr", A_STAT, 32'h0000_0002);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    rd("glitch_stat", A_STAT, 32'h0000_0002);
    rd("glitch_data", A_DATA, 32'h0000_0000);

    for (int i = 0; i < 17; i++) send_rx(8'h30 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_irq", irq, 1);
    rd("ovr_stat", A_STAT, 32'h0000_1007);
    rd("ovr_stat_clr", A_STAT, 32'h0000_1003);
    for (int i = 0; i < 16; i++) rd($sformatf("ovr_rd%0d", i), A_DATA, 32'h130 + i);
    rd("ovr_empty", A_DATA, 32'h0000_0000);
    check("ovr_irq_clear", irq, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
